lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- CPU-side load/store initiator: the requesting end of the data-memory port (mem_raddr/mem_read/mem_rdata, mem_waddr/mem_write/mem_wmask/mem_wdata).
- Accepts one byte/half/word/double load or store per transaction from the pipeline.
- Aligns address, builds byte mask, lane-shifts write data, drives the memory with a ready/valid handshake, then sign- or zero-extends load data back to the pipeline.
- Sits between EXU/LSU stage and the memory/DPI side; one outstanding transaction.

Parameters:
TIMEOUT_CYCLES, 0, cycles allowed in WAIT before error response; 0 disables timeout.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  pipeline request present
req_ready  out  1  initiator can accept request (high only in IDLE)
req_wen  in  1  1=store, 0=load
req_addr  in  64  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  load zero-extend when 1
req_wdata  in  64  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or timeout, valid with resp_valid
mem_raddr  out  64  8-byte-aligned read address
mem_read  out  1  read request
mem_waddr  out  64  8-byte-aligned write address
mem_write  out  1  write request
mem_wmask  out  8  byte-lane write mask
mem_wdata  out  64  lane-shifted write data
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  memory response/ack (reads and writes)
mem_rdata  in  64  read data, valid with mem_resp_valid

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs registered except req_ready = (state==IDLE).
- Reset (sync): state IDLE; mem_read, mem_write, resp_valid, resp_err = 0; mem_wmask, all addr/data outputs, resp_rdata = 0; timeout counter 0.
- IDLE: on req_valid, capture request. off = addr[2:0].
  - Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0. Go to RESP with resp_err=1. No mem_read/mem_write is ever asserted.
  - Otherwise go to REQ. Assert mem_read (load) or mem_write (store), never both.
  - Address fields: mem_raddr/mem_waddr = {addr[63:3],3'b0}. Only the active one is loaded; the other holds 0.
  - Mask: mem_wmask = (1,3,0xF,0xFF by size) << off for stores, 0 for loads.
  - Data: mem_wdata = (req_wdata masked to size) << 8*off.
- REQ: outputs held stable until mem_req_ready.
  - mem_req_ready & mem_resp_valid: go to RESP.
  - mem_req_ready alone: go to WAIT.
  - On leaving REQ, mem_read/mem_write deassert.
- WAIT: on mem_resp_valid, go to RESP. Counter increments each WAIT cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to RESP with resp_err=1. Any later mem_resp_valid is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load data: resp_rdata = extend(mem_rdata >> 8*off, size, unsigned). Byte/half/word sign-extend from bit 7/15/31 unless req_unsigned.
  - Stores and errors: resp_rdata = 0. Counter cleared.
- Latency: accept at cycle N.
  - mem request visible N+1.
  - Zero-wait memory (ready & resp_valid at N+1): resp_valid at N+2.
  - Misaligned: resp_valid at N+1.
- req_valid outside IDLE is ignored (req_ready=0).
- mem_resp_valid in IDLE or RESP is ignored.
- Reset mid-transaction: abandon. mem_read/mem_write are 0 after the reset edge, no resp_valid for the aborted request, req_ready=1 after reset.

Test Plan:
1. Load word signed, addr 0x80000004, mem_rdata=0x8765432112345678 with ready and resp_valid same cycle -> mem_raddr 0x80000000, mem_wmask 0, resp_rdata 0xFFFFFFFF87654321, resp_valid 2 cycles after accept.
2. Same load with req_unsigned=1; load byte unsigned at 0x80000007 -> 0x0000000087654321; then 0x0000000000000087.
3. Store byte, addr 0x80000003, req_wdata 0x12345678AB -> mem_write=1, mem_waddr 0x80000000, mem_wmask 0x08, mem_wdata 0x00000000AB000000, resp_rdata 0.
4. Load double at 0x80000004 -> mem_read/mem_write never asserted, resp_valid and resp_err=1 one cycle after accept.
5. mem_req_ready low 3 cycles, then high; mem_resp_valid 2 cycles later -> mem_read and mem_raddr stable for 4 cycles, req_ready=0 throughout, resp_valid 1 cycle after mem_resp_valid.
6. TIMEOUT_CYCLES=4, mem_resp_valid never asserted -> resp_err=1 pulse after 4 WAIT cycles. Separately, reset asserted in WAIT -> no resp_valid, mem_read=0, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
//
// Requesting end of the CPU data-memory port. Takes one load or store
// (byte/half/word/double) at a time from the LSU stage, aligns the address
// to 8 bytes, builds the byte-lane write mask, lane-shifts store data,
// presents the request to memory with a ready/valid handshake and returns
// sign- or zero-extended load data to the pipeline. One outstanding
// transaction at a time.
//
// Parameters
//   TIMEOUT_CYCLES  cycles tolerated in WAIT before an error response
//                   (0 = wait forever)
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/req_ready pipeline request handshake (ready only in IDLE)
//   req_wen             1 = store, 0 = load
//   req_addr            byte address
//   req_size            0 byte, 1 half, 2 word, 3 double
//   req_unsigned        zero-extend load data when 1
//   req_wdata           LSB-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            misaligned access or timeout, qualified by resp_valid
//   mem_raddr/mem_read  8-byte-aligned read address and read request
//   mem_waddr/mem_write 8-byte-aligned write address and write request
//   mem_wmask           byte-lane write enables
//   mem_wdata           lane-shifted write data
//   mem_req_ready       memory accepts the request this cycle
//   mem_resp_valid      memory read data / write acknowledge
//   mem_rdata           read data, qualified by mem_resp_valid
// ---------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,

    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,

    output logic [63:0] mem_raddr,
    output logic        mem_read,
    output logic [63:0] mem_waddr,
    output logic        mem_write,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic mis;
        case (sz)
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            2'd3:    mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] data_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Data is already shifted down so the addressed bytes sit at bit 0.
    function automatic logic [63:0] load_extend(input logic [63:0] d,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [63:0] r;
        case (sz)
            2'd0:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'd1:    r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] mem_raddr_q, mem_raddr_d;
    logic [63:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] cnt_q, cnt_d;

    // Attributes of the accepted request, needed again when the response
    // returns. Pure data: loaded on acceptance, no reset required.
    logic        wen_q;
    logic [2:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        accept;
    logic [2:0]  req_off;
    logic [63:0] req_aligned;
    logic [63:0] rd_lane;
    logic [63:0] load_data;
    logic        timeout_hit;

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_ready && req_valid;
    assign req_off     = req_addr[2:0];
    assign req_aligned = {req_addr[63:3], 3'b000};

    // Bring the addressed bytes of the returned doubleword down to bit 0.
    assign rd_lane     = mem_rdata >> {off_q, 3'b000};
    assign load_data   = load_extend(rd_lane, size_q, uns_q);

    // cnt_q counts WAIT cycles already spent; this cycle is number cnt_q+1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_raddr_d  = mem_raddr_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size, req_off)) begin
                        // Reported without ever touching the memory port.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else begin
                        state_d     = REQ;
                        mem_read_d  = !req_wen;
                        mem_write_d = req_wen;
                        if (req_wen) begin
                            mem_raddr_d = 64'd0;
                            mem_waddr_d = req_aligned;
                            mem_wmask_d = lane_mask(req_size) << req_off;
                            mem_wdata_d = (req_wdata & data_mask(req_size)) << {req_off, 3'b000};
                        end else begin
                            mem_raddr_d = req_aligned;
                            mem_waddr_d = 64'd0;
                            mem_wmask_d = 8'h00;
                            mem_wdata_d = 64'd0;
                        end
                    end
                end
            end

            REQ: begin
                // Request stays on the bus unchanged until memory takes it.
                if (mem_req_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_resp_valid) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = wen_q ? 64'd0 : load_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wen_q ? 64'd0 : load_data;
                    cnt_d        = 32'd0;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 64'd0;
                    cnt_d        = 32'd0;
                end
            end

            RESP: begin
                // Any straggling mem_resp_valid here is dropped.
                state_d = IDLE;
                cnt_d   = 32'd0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_raddr_q  <= 64'd0;
            mem_waddr_q  <= 64'd0;
            mem_wmask_q  <= 8'h00;
            mem_wdata_q  <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_raddr_q  <= mem_raddr_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            wen_q  <= req_wen;
            off_q  <= req_off;
            size_q <= req_size;
            uns_q  <= req_unsigned;
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_raddr  = mem_raddr_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_initiator
//
// Self-checking bench for lsu_mem_initiator. The main sequence drives
// requests and the memory side on the falling edge; expected responses are
// queued when a request is driven and popped by a monitor whenever the DUT
// raises resp_valid.
// ---------------------------------------------------------------------------
module tb_lsu_mem_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_raddr;
    logic        mem_read;
    logic [63:0] mem_waddr;
    logic        mem_write;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [64:0] exp_q[$];   // {err, rdata}
    logic [64:0] mon_e;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_raddr      (mem_raddr),
        .mem_read       (mem_read),
        .mem_waddr      (mem_waddr),
        .mem_write      (mem_write),
        .mem_wmask      (mem_wmask),
        .mem_wdata      (mem_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor and read/write exclusivity.
    always @(negedge clock) begin
        if (!reset) begin
            chk("rw_excl", 64'(mem_read & mem_write), 64'd0);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_rdata", resp_rdata, mon_e[63:0]);
                    chk("sb_err", 64'(resp_err), 64'(mon_e[64]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive_req(input logic wen, input logic [63:0] addr, input logic [1:0] sz,
                             input logic uns, input logic [63:0] wdata);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    task automatic do_txn(input string name, input logic wen, input logic [63:0] addr,
                          input logic [1:0] sz, input logic uns, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int rdy_dly, input int rsp_dly,
                          input logic [63:0] e_addr, input logic [7:0] e_mask,
                          input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                          input logic e_err);
        drive_req(wen, addr, sz, uns, wdata);
        exp_q.push_back({e_err, e_rdata});
        step();
        req_valid = 1'b0;
        chk({name, "_busy"}, 64'(req_ready), 64'd0);
        if (e_err) begin
            chk({name, "_mis_vld"}, 64'(resp_valid), 64'd1);
            chk({name, "_mis_err"}, 64'(resp_err), 64'd1);
            chk({name, "_mis_rd"}, 64'(mem_read), 64'd0);
            chk({name, "_mis_wr"}, 64'(mem_write), 64'd0);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk({name, "_rd"}, 64'(mem_read), 64'(!wen));
                chk({name, "_wr"}, 64'(mem_write), 64'(wen));
                chk({name, "_mask"}, 64'(mem_wmask), 64'(e_mask));
                chk({name, "_rdy_lo"}, 64'(req_ready), 64'd0);
                chk({name, "_vld_lo"}, 64'(resp_valid), 64'd0);
                if (wen) begin
                    chk({name, "_waddr"}, mem_waddr, e_addr);
                    chk({name, "_raddr0"}, mem_raddr, 64'd0);
                    chk({name, "_wdata"}, mem_wdata, e_wdata);
                end else begin
                    chk({name, "_raddr"}, mem_raddr, e_addr);
                    chk({name, "_waddr0"}, mem_waddr, 64'd0);
                end
                mem_req_ready  = (i == rdy_dly);
                mem_resp_valid = (i == rdy_dly) && (rsp_dly == 0);
                mem_rdata      = rdata;
                step();
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            for (int j = 1; j <= rsp_dly; j++) begin
                chk({name, "_wait_rd"}, 64'(mem_read), 64'd0);
                chk({name, "_wait_wr"}, 64'(mem_write), 64'd0);
                chk({name, "_wait_vld"}, 64'(resp_valid), 64'd0);
                chk({name, "_wait_rdy"}, 64'(req_ready), 64'd0);
                mem_resp_valid = (j == rsp_dly);
                mem_rdata      = rdata;
                step();
            end
            mem_resp_valid = 1'b0;
            chk({name, "_lat"}, 64'(resp_valid), 64'd1);
        end
        mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        step();
        chk({name, "_pulse"}, 64'(resp_valid), 64'd0);
        chk({name, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_wen        = 1'b0;
        req_addr       = 64'd0;
        req_size       = 2'd0;
        req_unsigned   = 1'b0;
        req_wdata      = 64'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'd0;
        step();
        step();
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_read", 64'(mem_read), 64'd0);
        chk("rst_write", 64'(mem_write), 64'd0);
        chk("rst_vld", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_mask", 64'(mem_wmask), 64'd0);
        chk("rst_raddr", mem_raddr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        reset = 1'b0;
        step();

        // Loads, zero-wait memory
        do_txn("ldw_s", 1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_8765_4321, 1'b0);
        do_txn("ldw_u", 1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_8765_4321, 1'b0);
        do_txn("ldb_u", 1'b0, 64'h8000_0007, 2'd0, 1'b1, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_0087, 1'b0);
        do_txn("ldb_s", 1'b0, 64'h8000_0007, 2'd0, 1'b0, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF87, 1'b0);
        do_txn("ldh_pos", 1'b0, 64'h8000_0002, 2'd1, 1'b0, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_1234, 1'b0);
        do_txn("ldh_neg", 1'b0, 64'h8000_0006, 2'd1, 1'b0, 64'd0, 64'h8765_4321_1234_5678, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8765, 1'b0);
        do_txn("ldd", 1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0, 64'h8765_4321_1234_5678, 1, 1,
               64'h8000_0008, 8'h00, 64'd0, 64'h8765_4321_1234_5678, 1'b0);

        // Stores; returned mem_rdata must not leak into resp_rdata
        do_txn("stb", 1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'h12_3456_78AB, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
               64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000, 64'd0, 1'b0);
        do_txn("sth", 1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'hFFFF_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1,
               64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'd0, 1'b0);
        do_txn("stw", 1'b1, 64'h8000_0004, 2'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0, 0,
               64'h8000_0000, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'd0, 1'b0);
        do_txn("std", 1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 2,
               64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);

        // Misaligned accesses
        do_txn("mis_d", 1'b0, 64'h8000_0004, 2'd3, 1'b0, 64'd0, 64'd0, 0, 0,
               64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
        do_txn("mis_h", 1'b0, 64'h8000_0001, 2'd1, 1'b0, 64'd0, 64'd0, 0, 0,
               64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
        do_txn("mis_w", 1'b1, 64'h8000_0002, 2'd2, 1'b0, 64'h1234, 64'd0, 0, 0,
               64'd0, 8'h00, 64'd0, 64'd0, 1'b1);

        // Memory back-pressure then delayed response
        do_txn("stall", 1'b0, 64'h8000_0000, 2'd2, 1'b0, 64'd0, 64'h1111_2222_3333_4444, 3, 2,
               64'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_3333_4444, 1'b0);

        // Timeout: memory accepts but never answers
        drive_req(1'b0, 64'h8000_0020, 2'd3, 1'b0, 64'd0);
        exp_q.push_back({1'b1, 64'd0});
        step();
        req_valid     = 1'b0;
        chk("to_rd", 64'(mem_read), 64'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("to_wait_vld", 64'(resp_valid), 64'd0);
            chk("to_wait_rd", 64'(mem_read), 64'd0);
            step();
        end
        chk("to_vld", 64'(resp_valid), 64'd1);
        chk("to_err", 64'(resp_err), 64'd1);
        mem_resp_valid = 1'b1;   // late answer, must be ignored
        mem_rdata      = 64'h5555_5555_5555_5555;
        step();
        mem_resp_valid = 1'b0;
        chk("to_late_vld", 64'(resp_valid), 64'd0);
        chk("to_late_rdy", 64'(req_ready), 64'd1);
        step();
        chk("to_late_vld2", 64'(resp_valid), 64'd0);

        // Reset while waiting for memory
        drive_req(1'b0, 64'h8000_0040, 2'd2, 1'b0, 64'd0);
        step();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rw_in_wait", 64'(req_ready), 64'd0);
        reset = 1'b1;
        step();
        chk("rw_rst_rd", 64'(mem_read), 64'd0);
        chk("rw_rst_rdy", 64'(req_ready), 64'd1);
        chk("rw_rst_vld", 64'(resp_valid), 64'd0);
        reset          = 1'b0;
        mem_resp_valid = 1'b1;   // stale answer for the abandoned request
        step();
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rw_post_vld", 64'(resp_valid), 64'd0);
            step();
        end

        // Normal operation after the abort
        do_txn("post_rst", 1'b0, 64'h8000_0005, 2'd0, 1'b0, 64'd0, 64'h0000_7F00_0000_0000, 0, 0,
               64'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_007F, 1'b0);

        step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
